// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory-ready timeout.
// Optional `MIPS_PERF_CNT_EN adds cycle and retired-instruction counters.
module mips_multicycle_ctrl #(
    parameter int OP_W    = 6,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic            i_Clock,
    input  logic            i_Reset,
    input  logic [OP_W-1:0] i_Opcode,
    input  logic [OP_W-1:0] i_Funct,
    input  logic            i_Mem_Ready,
    output logic            o_PC_Write,
    output logic            o_PC_Write_Cond,
    output logic            o_PC_Write_Cond_Ne,
    output logic            o_IorD,
    output logic            o_Mem_Read,
    output logic            o_Mem_Write,
    output logic            o_IR_Write,
    output logic [1:0]      o_Mem_to_Reg,
    output logic [1:0]      o_Reg_Dst,
    output logic            o_Reg_Write,
    output logic            o_Ori,
    output logic            o_ALU_Src_A,
    output logic [1:0]      o_ALU_Src_B,
    output logic [3:0]      o_ALU_Op,
    output logic [1:0]      o_PC_Source,
    output logic            o_Err,
    output logic [3:0]      o_State
`ifdef MIPS_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] o_Cycle_Count,
    output logic [CNT_W-1:0] o_Instr_Count
`endif
);

    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3,
        S_MEM_WB = 4'd4, S_MEM_WR = 4'd5, S_EXEC = 4'd6, S_ALU_WB = 4'd7,
        S_BRANCH = 4'd8, S_JUMP = 4'd9, S_JR = 4'd10, S_IMM_EXEC = 4'd11,
        S_HALT = 4'd15
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'h03);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'h05);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'h08);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'h0D);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);
    localparam logic [OP_W-1:0] FN_JR    = OP_W'(6'h08);
    localparam logic [7:0]      TO_LAST  = 8'(TIMEOUT - 1);

    state_t          r_state;
    logic [7:0]      r_cnt;
    logic            r_err;
    logic [OP_W-1:0] r_op;

    logic   w_wait;
    state_t w_wait_next;

    assign w_wait = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);

    always_comb begin
        w_wait_next = S_FETCH;
        if (r_state == S_FETCH)  w_wait_next = S_DECODE;
        if (r_state == S_MEM_RD) w_wait_next = S_MEM_WB;
    end

    // The opcode is captured in DECODE so later states never depend on the IR staying stable.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_op    <= '0;
        end else begin
            r_cnt <= '0;
            if (w_wait) begin
                if (i_Mem_Ready) begin
                    r_state <= w_wait_next;
                end else if (r_cnt == TO_LAST) begin
                    r_state <= S_HALT;
                    r_err   <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end else begin
                case (r_state)
                    S_DECODE: begin
                        r_op <= i_Opcode;
                        case (i_Opcode)
                            OP_RTYPE:       r_state <= (i_Funct == FN_JR) ? S_JR : S_EXEC;
                            OP_LW, OP_SW:   r_state <= S_MEM_ADDR;
                            OP_BEQ, OP_BNE: r_state <= S_BRANCH;
                            OP_J, OP_JAL:   r_state <= S_JUMP;
                            OP_ADDI, OP_ORI: r_state <= S_IMM_EXEC;
                            default: begin
                                r_state <= S_HALT;
                                r_err   <= 1'b1;
                            end
                        endcase
                    end
                    S_MEM_ADDR: r_state <= (r_op == OP_SW) ? S_MEM_WR : S_MEM_RD;
                    S_EXEC, S_IMM_EXEC: r_state <= S_ALU_WB;
                    S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_JR: r_state <= S_FETCH;
                    default: r_state <= S_HALT;
                endcase
            end
        end
    end

    // Outputs decode the state register directly; the FETCH strobes also follow Mem_Ready.
    always_comb begin
        o_PC_Write = 1'b0; o_PC_Write_Cond = 1'b0; o_PC_Write_Cond_Ne = 1'b0;
        o_IorD = 1'b0; o_Mem_Read = 1'b0; o_Mem_Write = 1'b0; o_IR_Write = 1'b0;
        o_Mem_to_Reg = 2'd0; o_Reg_Dst = 2'd0; o_Reg_Write = 1'b0; o_Ori = 1'b0;
        o_ALU_Src_A = 1'b0; o_ALU_Src_B = 2'd0; o_ALU_Op = 4'd0; o_PC_Source = 2'd0;
        if (!i_Reset) begin
            case (r_state)
                S_FETCH: begin
                    o_Mem_Read  = 1'b1;
                    o_ALU_Src_B = 2'd1;
                    o_IR_Write  = i_Mem_Ready;
                    o_PC_Write  = i_Mem_Ready;
                end
                S_DECODE:   o_ALU_Src_B = 2'd3;
                S_MEM_ADDR: begin o_ALU_Src_A = 1'b1; o_ALU_Src_B = 2'd2; end
                S_MEM_RD:   begin o_Mem_Read = 1'b1; o_IorD = 1'b1; end
                S_MEM_WB:   begin o_Reg_Write = 1'b1; o_Mem_to_Reg = 2'd1; end
                S_MEM_WR:   begin o_Mem_Write = 1'b1; o_IorD = 1'b1; end
                S_EXEC:     begin o_ALU_Src_A = 1'b1; o_ALU_Op = 4'd2; end
                S_ALU_WB: begin
                    o_Reg_Write = 1'b1;
                    o_Reg_Dst   = ((r_op == OP_ADDI) || (r_op == OP_ORI)) ? 2'd0 : 2'd1;
                end
                S_IMM_EXEC: begin
                    o_ALU_Src_A = 1'b1;
                    o_ALU_Src_B = 2'd2;
                    o_ALU_Op    = (r_op == OP_ORI) ? 4'd3 : 4'd0;
                    o_Ori       = (r_op == OP_ORI);
                end
                S_BRANCH: begin
                    o_ALU_Src_A        = 1'b1;
                    o_ALU_Op           = 4'd1;
                    o_PC_Source        = 2'd1;
                    o_PC_Write_Cond    = (r_op == OP_BEQ);
                    o_PC_Write_Cond_Ne = (r_op == OP_BNE);
                end
                S_JUMP: begin
                    o_PC_Write  = 1'b1;
                    o_PC_Source = 2'd2;
                    if (r_op == OP_JAL) begin
                        o_Reg_Write  = 1'b1;
                        o_Reg_Dst    = 2'd2;
                        o_Mem_to_Reg = 2'd2;
                    end
                end
                S_JR:    begin o_PC_Write = 1'b1; o_PC_Source = 2'd3; end
                default: ;
            endcase
        end
    end

    assign o_Err   = r_err;
    assign o_State = r_state;

`ifdef MIPS_PERF_CNT_EN
    logic w_retire;
    assign w_retire = (r_state == S_MEM_WB) || (r_state == S_ALU_WB) || (r_state == S_BRANCH) ||
                      (r_state == S_JUMP) || (r_state == S_JR) ||
                      ((r_state == S_MEM_WR) && i_Mem_Ready);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            o_Cycle_Count <= '0;
            o_Instr_Count <= '0;
        end else begin
            if (r_state != S_HALT) o_Cycle_Count <= o_Cycle_Count + 1'b1;
            if (w_retire)          o_Instr_Count <= o_Instr_Count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed-vector bench for mips_multicycle_ctrl, built with TIMEOUT=4.
module tb_mips_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] op = 6'd0, fn = 6'd0;
    logic rdy = 1'b0;
    logic pcw, pcc, pccn, iord, mr, mw, irw, rw, ori, sa, err;
    logic [1:0] m2r, rd, sb, pcsrc;
    logic [3:0] aluop, st;
    logic [21:0] all_ctl;
`ifdef MIPS_PERF_CNT_EN
    logic [31:0] cyc_cnt, ins_cnt;
`endif
    int tests = 0;
    int fails = 0;

    assign all_ctl = {pcw, pcc, pccn, iord, mr, mw, irw, m2r, rd, rw, ori, sa, sb, aluop, pcsrc};

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.OP_W(6), .TIMEOUT(4), .CNT_W(32)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Opcode(op), .i_Funct(fn), .i_Mem_Ready(rdy),
        .o_PC_Write(pcw), .o_PC_Write_Cond(pcc), .o_PC_Write_Cond_Ne(pccn), .o_IorD(iord),
        .o_Mem_Read(mr), .o_Mem_Write(mw), .o_IR_Write(irw), .o_Mem_to_Reg(m2r),
        .o_Reg_Dst(rd), .o_Reg_Write(rw), .o_Ori(ori), .o_ALU_Src_A(sa), .o_ALU_Src_B(sb),
        .o_ALU_Op(aluop), .o_PC_Source(pcsrc), .o_Err(err), .o_State(st)
`ifdef MIPS_PERF_CNT_EN
        , .o_Cycle_Count(cyc_cnt), .o_Instr_Count(ins_cnt)
`endif
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; op = 6'h00; fn = 6'h20;
        #12;
        tests++;
        if (all_ctl !== 22'd0) begin fails++; $display("FAIL reset_ctl: got %h expected 0", all_ctl); end
        tests++;
        if (st !== 4'd0 || err !== 1'b0) begin fails++; $display("FAIL reset_state: state %0d err %0d expected 0 0", st, err); end
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_rtype();
        logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
        op = 6'h00; fn = 6'h20; rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #3;
            tests++;
            if (st !== exp_st[i]) begin fails++; $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, st, exp_st[i]); end
            tests++;
            if (rw !== (i == 3) || (i == 3 && (rd !== 2'd1 || m2r !== 2'd0))) begin
                fails++; $display("FAIL rtype_wb[%0d]: rw %0d rd %0d m2r %0d expected rw %0d rd 1 m2r 0", i, rw, rd, m2r, (i == 3));
            end
            if (i == 2) begin
                tests++;
                if (aluop !== 4'd2 || sa !== 1'b1 || sb !== 2'd0) begin fails++; $display("FAIL rtype_exec: aluop %0d sa %0d sb %0d expected 2 1 0", aluop, sa, sb); end
            end
            cyc();
        end
`ifdef MIPS_PERF_CNT_EN
        #3;
        tests++;
        if (cyc_cnt !== 32'd4 || ins_cnt !== 32'd1) begin fails++; $display("FAIL perf_cnt: cycles %0d instrs %0d expected 4 1", cyc_cnt, ins_cnt); end
`endif
    endtask

    task automatic test_lw_wait();
        logic [3:0] exp_st [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
        logic       rdy_v  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            op = (i == 0) ? 6'h3F : 6'h23;
            rdy = rdy_v[i];
            #3;
            tests++;
            if (st !== exp_st[i]) begin fails++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, st, exp_st[i]); end
            if (exp_st[i] == 4'd3) begin
                tests++;
                if (mr !== 1'b1 || iord !== 1'b1) begin fails++; $display("FAIL lw_memrd[%0d]: mr %0d iord %0d expected 1 1", i, mr, iord); end
            end
            tests++;
            if (rw !== (i == 6) || (i == 6 && m2r !== 2'd1)) begin fails++; $display("FAIL lw_wb[%0d]: rw %0d m2r %0d", i, rw, m2r); end
            cyc();
        end
    endtask

    task automatic test_sw();
        logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
        op = 6'h2B; rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #3;
            tests++;
            if (st !== exp_st[i]) begin fails++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, st, exp_st[i]); end
            tests++;
            if (mw !== (i == 3) || (i == 3 && iord !== 1'b1)) begin fails++; $display("FAIL sw_write[%0d]: mw %0d iord %0d", i, mw, iord); end
            cyc();
        end
    endtask

    task automatic test_imm();
        logic [5:0] ops [2] = '{6'h08, 6'h0D};
        logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd11, 4'd7};
        rdy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            op = ops[k];
            for (int i = 0; i < 4; i++) begin
                #3;
                tests++;
                if (st !== exp_st[i]) begin fails++; $display("FAIL imm%0d_state[%0d]: got %0d expected %0d", k, i, st, exp_st[i]); end
                if (i == 2) begin
                    tests++;
                    if (aluop !== ((k == 1) ? 4'd3 : 4'd0) || ori !== (k == 1) || sb !== 2'd2 || sa !== 1'b1) begin
                        fails++; $display("FAIL imm%0d_exec: aluop %0d ori %0d sb %0d sa %0d", k, aluop, ori, sb, sa);
                    end
                end
                if (i == 3) begin
                    tests++;
                    if (rw !== 1'b1 || rd !== 2'd0) begin fails++; $display("FAIL imm%0d_wb: rw %0d rd %0d expected 1 0", k, rw, rd); end
                end
                cyc();
            end
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops [2] = '{6'h04, 6'h05};
        logic [3:0] exp_st [3] = '{4'd0, 4'd1, 4'd8};
        rdy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            op = ops[k];
            for (int i = 0; i < 3; i++) begin
                #3;
                tests++;
                if (st !== exp_st[i]) begin fails++; $display("FAIL br%0d_state[%0d]: got %0d expected %0d", k, i, st, exp_st[i]); end
                if (i == 2) begin
                    tests++;
                    if (pcc !== (k == 0) || pccn !== (k == 1) || pcsrc !== 2'd1 || aluop !== 4'd1 || pcw !== 1'b0) begin
                        fails++; $display("FAIL br%0d_ctl: cond %0d cond_ne %0d pcsrc %0d aluop %0d pcw %0d", k, pcc, pccn, pcsrc, aluop, pcw);
                    end
                end
                cyc();
            end
        end
    endtask

    task automatic test_jump();
        logic [5:0] ops [3] = '{6'h03, 6'h02, 6'h00};
        logic [3:0] exp_st [3][3] = '{'{4'd0, 4'd1, 4'd9}, '{4'd0, 4'd1, 4'd9}, '{4'd0, 4'd1, 4'd10}};
        rdy = 1'b1; fn = 6'h08;
        for (int k = 0; k < 3; k++) begin
            op = ops[k];
            for (int i = 0; i < 3; i++) begin
                #3;
                tests++;
                if (st !== exp_st[k][i]) begin fails++; $display("FAIL jmp%0d_state[%0d]: got %0d expected %0d", k, i, st, exp_st[k][i]); end
                if (i == 2) begin
                    tests++;
                    if (k == 0 && (pcw !== 1'b1 || pcsrc !== 2'd2 || rw !== 1'b1 || rd !== 2'd2 || m2r !== 2'd2)) begin
                        fails++; $display("FAIL jal_ctl: pcw %0d pcsrc %0d rw %0d rd %0d m2r %0d expected 1 2 1 2 2", pcw, pcsrc, rw, rd, m2r);
                    end else if (k == 1 && (pcw !== 1'b1 || pcsrc !== 2'd2 || rw !== 1'b0)) begin
                        fails++; $display("FAIL j_ctl: pcw %0d pcsrc %0d rw %0d expected 1 2 0", pcw, pcsrc, rw);
                    end else if (k == 2 && (pcw !== 1'b1 || pcsrc !== 2'd3 || rw !== 1'b0)) begin
                        fails++; $display("FAIL jr_ctl: pcw %0d pcsrc %0d rw %0d expected 1 3 0", pcw, pcsrc, rw);
                    end
                end
                cyc();
            end
        end
        fn = 6'h20;
    endtask

    task automatic test_timeout_boundary();
        logic [3:0] exp_st [7] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd6, 4'd7};
        logic       rdy_v  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        op = 6'h00; fn = 6'h20;
        for (int i = 0; i < 7; i++) begin
            rdy = rdy_v[i];
            #3;
            tests++;
            if (st !== exp_st[i] || err !== 1'b0) begin fails++; $display("FAIL to_edge[%0d]: state %0d err %0d expected %0d 0", i, st, err, exp_st[i]); end
            cyc();
        end
    endtask

    task automatic test_timeout();
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #3;
            tests++;
            if (st !== 4'd0 || mr !== 1'b1 || irw !== 1'b0) begin fails++; $display("FAIL to_wait[%0d]: state %0d mr %0d irw %0d expected 0 1 0", i, st, mr, irw); end
            cyc();
        end
        #3;
        tests++;
        if (st !== 4'd15 || err !== 1'b1 || all_ctl !== 22'd0) begin fails++; $display("FAIL to_halt: state %0d err %0d ctl %h expected 15 1 0", st, err, all_ctl); end
        rst = 1'b1;
        #1;
        tests++;
        if (st !== 4'd0 || err !== 1'b0) begin fails++; $display("FAIL to_reset: state %0d err %0d expected 0 0", st, err); end
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_illegal();
        logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd15, 4'd15};
        op = 6'h3F; rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #3;
            tests++;
            if (st !== exp_st[i]) begin fails++; $display("FAIL ill_state[%0d]: got %0d expected %0d", i, st, exp_st[i]); end
            if (i >= 2) begin
                tests++;
                if (err !== 1'b1 || all_ctl !== 22'd0) begin fails++; $display("FAIL ill_halt[%0d]: err %0d ctl %h expected 1 0", i, err, all_ctl); end
            end
            cyc();
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        op = 6'h2B; rdy = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        rdy = 1'b0;
        #3;
        tests++;
        if (st !== 4'd5 || mw !== 1'b1) begin fails++; $display("FAIL mid_pre: state %0d mw %0d expected 5 1", st, mw); end
        rst = 1'b1;
        #1;
        tests++;
        if (mw !== 1'b0 || st !== 4'd0 || all_ctl !== 22'd0) begin fails++; $display("FAIL mid_reset: mw %0d state %0d ctl %h expected 0 0 0", mw, st, all_ctl); end
        cyc();
        rst = 1'b0;
        rdy = 1'b1;
        #3;
        tests++;
        if (st !== 4'd0 || err !== 1'b0 || irw !== 1'b1) begin fails++; $display("FAIL mid_restart: state %0d err %0d irw %0d expected 0 0 1", st, err, irw); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw();
        test_imm();
        test_branch();
        test_jump();
        test_timeout_boundary();
        test_timeout();
        test_illegal();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS control path.
- A Moore/Mealy FSM sequences FETCH, DECODE, EXECUTE, MEM and WRITEBACK over several clocks, so one ALU and one unified memory can be shared.
- Memory is handled by a variable-latency ready handshake with a timeout.
- Sits between the instruction register (opcode/funct) and the datapath muxes, register file, PC and memory port.

Parameters:
- OP_W, 6, opcode and funct field width.
- TIMEOUT, 16, maximum cycles to wait for Mem_Ready in any memory state before error; range 1..255.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Opcode  in  OP_W  instruction[31:26], taken from the IR.
- Funct  in  OP_W  instruction[5:0].
- Mem_Ready  in  1  memory completes the current access this cycle.
- PC_Write  out  1  unconditional PC load.
- PC_Write_Cond  out  1  PC load if Zero (beq).
- PC_Write_Cond_Ne  out  1  PC load if !Zero (bne).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- Mem_Read  out  1  memory read request.
- Mem_Write  out  1  memory write request.
- IR_Write  out  1  instruction register load.
- Mem_to_Reg  out  2  writeback data: 0 = ALUOut, 1 = MDR, 2 = PC.
- Reg_Dst  out  2  write register: 0 = rt, 1 = rd, 2 = $31.
- Reg_Write  out  1  register file write enable.
- Ori  out  1  zero-extend the immediate.
- ALU_Src_A  out  1  ALU A input: 0 = PC, 1 = rs.
- ALU_Src_B  out  2  ALU B input: 0 = rt, 1 = constant 4, 2 = imm, 3 = imm<<2.
- ALU_Op  out  4  ALU operation: 0 = add, 1 = sub, 2 = funct-decoded, 3 = or.
- PC_Source  out  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = rs.
- Err  out  1  sticky error flag: illegal opcode or memory timeout.
- State  out  4  current state encoding, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, ALU_WB=7, BRANCH=8, JUMP=9, JR=10, IMM_EXEC=11, HALT=15.
- Reset (asynchronous):
  - State = FETCH, timeout counter = 0, Err = 0.
  - All control outputs are 0 while Reset is high.
- FETCH:
  - Asserts Mem_Read=1, IorD=0, ALU_Src_A=0, ALU_Src_B=1, ALU_Op=add, PC_Source=0.
  - IR_Write and PC_Write are asserted only in the cycle Mem_Ready=1; that cycle also transitions to DECODE.
- DECODE:
  - Drives ALU_Src_A=0, ALU_Src_B=3, ALU_Op=add (branch target into ALUOut).
  - Next state by opcode:
    - 0x00 with Funct 0x08 -> JR; 0x00 otherwise -> EXEC.
    - 0x23 (lw) and 0x2B (sw) -> MEM_ADDR.
    - 0x04 (beq) and 0x05 (bne) -> BRANCH.
    - 0x02 (j) and 0x03 (jal) -> JUMP.
    - 0x08 (addi) and 0x0D (ori) -> IMM_EXEC.
    - Any other opcode -> HALT with Err=1.
- MEM_ADDR: ALU_Src_A=1, ALU_Src_B=2, ALU_Op=add; goes to MEM_RD if lw, MEM_WR if sw.
- MEM_RD: Mem_Read=1, IorD=1; waits for Mem_Ready, then goes to MEM_WB.
- MEM_WB: Reg_Write=1, Reg_Dst=0, Mem_to_Reg=1; goes to FETCH.
- MEM_WR: Mem_Write=1, IorD=1; goes to FETCH in the Mem_Ready cycle.
- EXEC: ALU_Src_A=1, ALU_Src_B=0, ALU_Op=2; goes to ALU_WB.
- ALU_WB: Reg_Write=1, Reg_Dst=1, Mem_to_Reg=0. For IMM_EXEC instructions, Reg_Dst=0 instead. Goes to FETCH.
- IMM_EXEC:
  - ALU_Src_A=1, ALU_Src_B=2; ALU_Op=add for addi, or for ori.
  - Ori=1 for ori.
  - Goes to ALU_WB.
- BRANCH:
  - ALU_Src_A=1, ALU_Src_B=0, ALU_Op=sub, PC_Source=1.
  - PC_Write_Cond=1 for beq, PC_Write_Cond_Ne=1 for bne.
  - Goes to FETCH.
- JUMP:
  - PC_Write=1, PC_Source=2.
  - For jal, also Reg_Write=1, Reg_Dst=2, Mem_to_Reg=2; this writes the already-incremented PC into $31.
  - Goes to FETCH.
- JR: PC_Write=1, PC_Source=3, Reg_Write=0; goes to FETCH.
- Latency with zero wait states (Mem_Ready high in the first cycle of each access):
  - R-type, addi, ori: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, bne, j, jal, jr: 3 cycles.
  - Each extra wait cycle adds 1.
- Timeout:
  - In FETCH, MEM_RD and MEM_WR the counter increments each cycle Mem_Ready=0.
  - The counter clears on state exit.
  - When the counter reaches TIMEOUT with Mem_Ready still 0, the FSM goes to HALT and sets Err=1.
  - A Mem_Ready arriving in the same cycle the count reaches TIMEOUT wins: normal progress, no error.
- HALT:
  - All control outputs are 0; Err is held.
  - The FSM leaves HALT only on Reset.
- Reset asserted mid-instruction aborts it immediately. No partial write is issued after the reset edge.
- Opcode and Funct are sampled only in DECODE and later states. Their values during FETCH are ignored.

Optional Feature:
- Macro: MIPS_PERF_CNT_EN.
- When defined, two outputs are added: Cycle_Count[CNT_W] and Instr_Count[CNT_W].
  - Both reset to 0.
  - Cycle_Count increments every cycle not in HALT.
  - Instr_Count increments on each transition into FETCH from a terminal state.
  - Both wrap modulo 2^CNT_W.
- When undefined, the ports and counter logic are absent and the remaining behaviour is identical.

Test Plan:
- Reset, then Opcode=0x00, Funct=0x20, Mem_Ready=1 -> states 0,1,6,7,0. Reg_Write=1 with Reg_Dst=1 only in cycle 4. Cycle_Count=4 and Instr_Count=1 (if enabled).
- lw (0x23) with Mem_Ready low for 2 cycles in MEM_RD -> 7 cycles total. Mem_Read held high throughout MEM_RD. Reg_Write with Mem_to_Reg=1 in the final cycle.
- beq (0x04) then bne (0x05) -> each takes 3 cycles. In state 8, PC_Write_Cond=1 and PC_Write_Cond_Ne=1 respectively, with PC_Source=1 and ALU_Op=1.
- jal (0x03) -> in state 9, PC_Write=1, PC_Source=2, Reg_Write=1, Reg_Dst=2, Mem_to_Reg=2. jr (0x00/0x08) -> PC_Source=3 with Reg_Write=0.
- TIMEOUT=4 with Mem_Ready held 0 in FETCH -> enters HALT (15) after 4 cycles, Err=1, outputs 0. Reset returns the FSM to FETCH with Err=0.
- Opcode=0x3F in DECODE -> HALT, Err=1. Reset asserted during MEM_WR -> Mem_Write drops to 0 immediately and State=0.
